// File: rtl/ram_initiator.sv
// Byte-addressed request adapter onto the split even/odd RAM banks: 8/16-bit big-endian
// accesses, one outstanding request, valid/ready response. Window check: RAM_INITIATOR_BOUNDS_EN.
module ram_initiator #(
  parameter int ADDRBITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [14:0] read_addr_even,
  output logic [14:0] write_addr_even,
  input  logic [7:0]  read_data_even,
  output logic [7:0]  write_data_even,
  output logic        write_en_even,
  output logic [14:0] read_addr_odd,
  output logic [14:0] write_addr_odd,
  input  logic [7:0]  read_data_odd,
  output logic [7:0]  write_data_odd,
  output logic        write_en_odd
);

  // state   | meaning
  // IDLE    | waiting for a request, req_ready high
  // ISSUE   | bank addresses driven, write strobes active for writes
  // CAPTURE | bank read data arriving, folded into rsp_data
  // RESP    | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  if (ADDRBITS < 2 || ADDRBITS > 14) begin : g_bad_addrbits
    $error("ram_initiator: ADDRBITS must be in 2..14");
  end

  state_t      state;
  logic        ready_q;
  logic        wr_q, wide_q, a0_q;
  logic        we_even_q, we_odd_q;
  logic [14:0] idx_even_q, idx_odd_q;
  logic [7:0]  wd_even_q, wd_odd_q;

  logic [14:0] idx_even_c, idx_odd_c;
  logic [7:0]  wd_even_c, wd_odd_c;
  logic        touch_even_c, touch_odd_c;
  logic        err_c;

`ifdef RAM_INITIATOR_BOUNDS_EN
  localparam int          SIZE    = 1 << ADDRBITS;
  localparam logic [15:0] RAMBASE = 16'(16'h4000 - SIZE);
  localparam logic [15:0] RAMLAST = 16'h3FFF;

  function automatic logic in_window(input logic [15:0] a);
    return (a >= RAMBASE) && (a <= RAMLAST);
  endfunction

  logic [15:0] addr_p1;
  always_comb begin
    addr_p1 = req_addr + 16'd1;
    err_c   = !in_window(req_addr) || (req_wide && !in_window(addr_p1));
  end
`else
  assign err_c = 1'b0;
`endif

  // A wide access at odd A puts byte A+1 in the even bank one word further on.
  always_comb begin
    idx_odd_c    = req_addr[15:1];
    idx_even_c   = (req_wide && req_addr[0]) ? req_addr[15:1] + 15'd1 : req_addr[15:1];
    touch_even_c = req_wide || !req_addr[0];
    touch_odd_c  = req_wide || req_addr[0];
    wd_even_c    = (req_wide && !req_addr[0]) ? req_wdata[15:8] : req_wdata[7:0];
    wd_odd_c     = (req_wide &&  req_addr[0]) ? req_wdata[15:8] : req_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= 16'h0000;
      wr_q       <= 1'b0;
      wide_q     <= 1'b0;
      a0_q       <= 1'b0;
      we_even_q  <= 1'b0;
      we_odd_q   <= 1'b0;
      idx_even_q <= 15'h0000;
      idx_odd_q  <= 15'h0000;
      wd_even_q  <= 8'h00;
      wd_odd_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ready_q  <= 1'b0;
            wr_q     <= req_write;
            wide_q   <= req_wide;
            a0_q     <= req_addr[0];
            rsp_data <= 16'h0000;
            if (err_c) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              idx_even_q <= idx_even_c;
              idx_odd_q  <= idx_odd_c;
              wd_even_q  <= wd_even_c;
              wd_odd_q   <= wd_odd_c;
              we_even_q  <= req_write && touch_even_c;
              we_odd_q   <= req_write && touch_odd_c;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          we_even_q <= 1'b0;
          we_odd_q  <= 1'b0;
          if (wr_q) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!wide_q)
            rsp_data <= {8'h00, a0_q ? read_data_odd : read_data_even};
          else if (a0_q)
            rsp_data <= {read_data_odd, read_data_even};
          else
            rsp_data <= {read_data_even, read_data_odd};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 16'h0000;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so a reset landing in ISSUE cannot write.
  assign req_ready       = ready_q && !reset;
  assign write_en_even   = we_even_q && !reset;
  assign write_en_odd    = we_odd_q && !reset;
  assign read_addr_even  = idx_even_q;
  assign write_addr_even = idx_even_q;
  assign read_addr_odd   = idx_odd_q;
  assign write_addr_odd  = idx_odd_q;
  assign write_data_even = wd_even_q;
  assign write_data_odd  = wd_odd_q;

endmodule

// File: doc/ram_initiator.md
# ram_initiator

Requester-side adapter that converts byte-addressed CPU/DMA memory requests into accesses on the split even/odd banked RAM ports. It handles 8- and 16-bit (big-endian) accesses, including unaligned words that straddle both banks. It absorbs the banks' one-cycle synchronous read latency and returns each result through a valid/ready response channel. It sits between the F8 core's memory sequencer and the `ram` block; its RAM-side ports connect one-to-one to the `ram` ports of the same name.

## Interface
- `ADDRBITS`, default 10; RAM window size `1 << ADDRBITS` bytes, occupying `RAMBASE = 0x4000 - SIZE` .. 0x3FFF; must match the attached `ram`.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when valid & ready.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wide`  in  1  1 = 16-bit access, 0 = 8-bit.
- `req_addr`  in  16  byte address A.
- `req_wdata`  in  16  write data; byte uses [7:0]; wide: [15:8] → A, [7:0] → A+1.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when valid & ready.
- `rsp_data`  out  16  read data; byte → {0x00, byte}; wide → {mem[A], mem[A+1]}; writes/errors → 0x0000.
- `rsp_err`  out  1  access rejected (outside window).
- `read_addr_even`, `write_addr_even`  out  15  even-bank word index.
- `read_data_even`  in  8  even-bank data, valid one cycle after address.
- `write_data_even`  out  8; `write_en_even`  out  1.
- `read_addr_odd`, `write_addr_odd`, `read_data_odd`, `write_data_odd`, `write_en_odd`: odd-bank equivalents.

## Operation
- Byte at address A lives in bank A[0] at index A[15:1]. Wide at even A uses index A>>1 in both banks. Wide at odd A uses odd index A>>1 and even index (A+1)>>1. A+1 is computed modulo 2^16.
- States:
  - IDLE: `req_ready`=1. On accept, latch the request, compute bank indices and byte lanes, and go to ISSUE, or to RESP if error.
  - ISSUE: drive addresses. A write drives the `write_en` of each touched bank for exactly this one cycle, then goes to RESP. A read goes to CAPTURE.
  - CAPTURE: register the bank data into `rsp_data` with byte ordering by A[0], then go to RESP.
  - RESP: `rsp_valid`=1 with data and error held stable; on `rsp_ready` go to IDLE.
- Read and write address outputs hold the latched indices outside ISSUE. Untouched banks never see `write_en`.
- An error is any touched byte outside RAMBASE..0x3FFF, including a wide access at 0x3FFF. On error: no bank access at all, `rsp_err`=1, `rsp_data`=0.
- `req_ready` is 0 in every state except IDLE. There is one outstanding request at a time.

## Timing
- Accept at edge E0. Read: ISSUE in cycle after E0, RAM samples at E1, CAPTURE, `rsp_valid` high after E2 (3 cycles). Write: bank write at E1, `rsp_valid` high after E1 (2 cycles). Error: `rsp_valid` high after E0 (1 cycle).
- If `rsp_ready` is 1 in the first RESP cycle, `req_ready` is high the next cycle.
- A read issued after a write response sees the written data, because the write has completed by then.
- Reset values: `req_ready`=0 while `reset`=1, then 1 (IDLE). `rsp_valid`, `rsp_err`, `rsp_data`, all address and write-data outputs, and both `write_en` outputs are 0.
- `write_en_*` are gated by `!reset`. A reset asserted during ISSUE writes nothing. Reset at any state returns to IDLE and discards the pending request and response.

## Configuration
- `RAM_INITIATOR_BOUNDS_EN` defined: window check active as above.
- Undefined: no check. `rsp_err` is constant 0, every access is issued, and indices are A[15:1] untruncated; the `ram` block's modulo rebasing determines aliasing.

## Test plan
- ADDRBITS=10. Byte write 0x3C00 ← 0x5A: one-cycle `write_en_even` with `write_addr_even`=0x1E00 and data 0x5A, `rsp_valid` 2 cycles after accept. Byte read 0x3C00 → `rsp_data`=0x005A, 3 cycles after accept.
- Wide write 0x3C01 ← 0x1234: same cycle, odd bank index 0x1E00 gets 0x12 and even bank index 0x1E01 gets 0x34. Wide read 0x3C01 → 0x1234. Wide read 0x3C02 (aligned) → both banks index 0x1E01.
- With macro: byte write 0x3BFF → no `write_en`, `rsp_err`=1, `rsp_data`=0 after 1 cycle. Wide read 0x3FFF → `rsp_err`=1.
- Backpressure: `rsp_ready`=0 for 5 cycles after a read of 0x3C00 → `rsp_valid`, `rsp_data`=0x005A held, `req_ready`=0. Release → `req_ready`=1 the next cycle.
- Reset asserted in the ISSUE cycle of a write to 0x3C10 ← 0x77 → no `write_en`. All outputs take reset values. A subsequent read of 0x3C10 returns the prior contents.
- Without macro: byte read 0x7C00 → `read_addr_even`=0x3E00, `rsp_err`=0, data returned.
